// File: rtl/bolme_birimi_pkg.sv
// bolme_birimi_pkg
//   Shared definitions for the RV32M divide unit: operation codes, FSM state
//   encoding, the fixed special-case result values and the small helpers
//   used when operands are latched.
package bolme_birimi_pkg;

    // Operation codes as they arrive on islem_i.
    typedef enum logic [1:0] {
        BOL_DIV  = 2'b00,
        BOL_DIVU = 2'b01,
        BOL_REM  = 2'b10,
        BOL_REMU = 2'b11
    } islem_t;

    // Divider FSM state encoding.
    typedef enum logic [1:0] {
        BOL_BOSTA   = 2'b00,
        BOL_HESAPLA = 2'b01,
        BOL_DUZELT  = 2'b10
    } durum_t;

    // Quotient returned for any division by zero.
    localparam logic [31:0] BOL_SIFIR_BOLUM = 32'hFFFF_FFFF;
    // Most negative value: signed-overflow dividend and its quotient.
    localparam logic [31:0] BOL_TASMA       = 32'h8000_0000;
    // Divisor value -1, the other half of the signed-overflow case.
    localparam logic [31:0] BOL_EKSI_BIR    = 32'hFFFF_FFFF;

    // DIV and REM treat their operands as signed; DIVU and REMU do not.
    function automatic logic isaretli(input islem_t islem);
        return ~islem[0];
    endfunction

    // Two's-complement magnitude of a signed 32-bit value. 0x80000000 maps
    // to itself, which is exactly the unsigned magnitude we want.
    function automatic logic [31:0] mutlak(input logic [31:0] deger);
        return deger[31] ? (~deger + 32'd1) : deger;
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [31:0] isaret_uygula(input logic [31:0] deger,
                                                  input logic        negatif);
        return negatif ? (~deger + 32'd1) : deger;
    endfunction

endpackage

// File: rtl/bolme_adimi.sv
// bolme_adimi
//   One iteration of radix-2 restoring division, purely combinational.
//   The pair {kalan, bolum} is shifted left by one; the divisor is trial-
//   subtracted from the upper half. If the subtraction does not borrow the
//   difference becomes the new partial remainder and the quotient LSB is 1;
//   otherwise the shifted remainder is kept (restore) and the LSB is 0.
//
//   Ports
//     kalan          in   partial remainder (always < bolen)
//     bolum          in   quotient / remaining dividend bits
//     bolen          in   divisor magnitude
//     kalan_sonraki  out  partial remainder after this step
//     bolum_sonraki  out  quotient after this step
module bolme_adimi #(
    parameter int VERI_BIT = 32
) (
    input  logic [VERI_BIT-1:0] kalan,
    input  logic [VERI_BIT-1:0] bolum,
    input  logic [VERI_BIT-1:0] bolen,
    output logic [VERI_BIT-1:0] kalan_sonraki,
    output logic [VERI_BIT-1:0] bolum_sonraki
);

    // One extra bit: the shifted remainder can reach 2*bolen-1, which needs
    // VERI_BIT+1 bits for unsigned divisors near the top of the range, and
    // the MSB of the difference then doubles as the borrow flag.
    logic [VERI_BIT:0] kaydirilmis;
    logic [VERI_BIT:0] fark;

    always_comb begin
        kaydirilmis = {kalan, bolum[VERI_BIT-1]};
        fark        = kaydirilmis - {1'b0, bolen};
        if (fark[VERI_BIT]) begin
            kalan_sonraki = kaydirilmis[VERI_BIT-1:0];
            bolum_sonraki = {bolum[VERI_BIT-2:0], 1'b0};
        end else begin
            kalan_sonraki = fark[VERI_BIT-1:0];
            bolum_sonraki = {bolum[VERI_BIT-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/bolme_birimi.sv
// bolme_birimi
//   Iterative RV32M divide unit (DIV, DIVU, REM, REMU) for the execute stage.
//   Radix-2 restoring division, one quotient bit per clock over 32 clocks,
//   with single-cycle fast paths for divide-by-zero and signed overflow.
//   All outputs are registered; the pipeline stalls while mesgul_o is high.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   BOSTA   | idle, accepts basla_i (unless iptal_i)
//   HESAPLA | 32 restoring iterations, counter 31 down to 0
//   DUZELT  | select quotient/remainder, fix sign, strobe gecerli_o
//
//   Ports
//     clk_i       in   clock, rising edge
//     rst_ni      in   asynchronous active-low reset
//     basla_i     in   start request, sampled only in BOSTA
//     islem_i     in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//     bolunen_i   in   dividend (rs1)
//     bolen_i     in   divisor (rs2)
//     rd_adres_i  in   destination register, latched on accept
//     iptal_i     in   synchronous flush, overrides everything but reset
//     mesgul_o    out  operation in flight (HESAPLA or DUZELT)
//     gecerli_o   out  one-cycle result strobe
//     sonuc_o     out  quotient or remainder, held between results
//     rd_adres_o  out  destination register aligned with gecerli_o
module bolme_birimi
    import bolme_birimi_pkg::*;
#(
    parameter int VERI_BIT  = 32,
    parameter int SAYAC_BIT = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                basla_i,
    input  logic [1:0]          islem_i,
    input  logic [VERI_BIT-1:0] bolunen_i,
    input  logic [VERI_BIT-1:0] bolen_i,
    input  logic [4:0]          rd_adres_i,
    input  logic                iptal_i,
    output logic                mesgul_o,
    output logic                gecerli_o,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic [4:0]          rd_adres_o
);

    durum_t                durum;
    islem_t                islem;
    logic [4:0]            rd_adres;
    logic [SAYAC_BIT-1:0]  sayac;
    logic [VERI_BIT-1:0]   kalan;
    logic [VERI_BIT-1:0]   bolum;
    logic [VERI_BIT-1:0]   bolen;
    logic                  bolum_negatif;
    logic                  kalan_negatif;

    logic [VERI_BIT-1:0]   kalan_sonraki;
    logic [VERI_BIT-1:0]   bolum_sonraki;

    islem_t                yeni_islem;
    logic                  yeni_isaretli;
    logic                  sifira_bolme;
    logic                  tasma;
    logic [VERI_BIT-1:0]   secilen;

    bolme_adimi #(
        .VERI_BIT (VERI_BIT)
    ) u_adim (
        .kalan         (kalan),
        .bolum         (bolum),
        .bolen         (bolen),
        .kalan_sonraki (kalan_sonraki),
        .bolum_sonraki (bolum_sonraki)
    );

    // Fast-path detection looks at the raw request operands at accept time.
    always_comb begin
        yeni_islem    = islem_t'(islem_i);
        yeni_isaretli = isaretli(yeni_islem);
        sifira_bolme  = (bolen_i == '0);
        tasma         = yeni_isaretli && (bolunen_i == BOL_TASMA)
                        && (bolen_i == BOL_EKSI_BIR);
    end

    // Remainder ops take the partial remainder, divide ops the quotient.
    always_comb begin
        if (islem[1]) begin
            secilen = isaret_uygula(kalan, kalan_negatif);
        end else begin
            secilen = isaret_uygula(bolum, bolum_negatif);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum         <= BOL_BOSTA;
            islem         <= BOL_DIV;
            rd_adres      <= '0;
            sayac         <= '0;
            kalan         <= '0;
            bolum         <= '0;
            bolen         <= '0;
            bolum_negatif <= 1'b0;
            kalan_negatif <= 1'b0;
            mesgul_o      <= 1'b0;
            gecerli_o     <= 1'b0;
            sonuc_o       <= '0;
            rd_adres_o    <= '0;
        end else if (iptal_i) begin
            // Flush: drop the operation silently, keep the last result.
            durum     <= BOL_BOSTA;
            sayac     <= '0;
            mesgul_o  <= 1'b0;
            gecerli_o <= 1'b0;
        end else begin
            case (durum)
                BOL_BOSTA: begin
                    gecerli_o <= 1'b0;
                    if (basla_i) begin
                        islem    <= yeni_islem;
                        rd_adres <= rd_adres_i;
                        mesgul_o <= 1'b1;
                        sayac    <= SAYAC_BIT'(VERI_BIT - 1);
                        bolen    <= yeni_isaretli ? mutlak(bolen_i) : bolen_i;
                        if (sifira_bolme) begin
                            // Final values are loaded directly; the raw
                            // dividend is the remainder regardless of sign.
                            bolum         <= BOL_SIFIR_BOLUM;
                            kalan         <= bolunen_i;
                            bolum_negatif <= 1'b0;
                            kalan_negatif <= 1'b0;
                            durum         <= BOL_DUZELT;
                        end else if (tasma) begin
                            bolum         <= BOL_TASMA;
                            kalan         <= '0;
                            bolum_negatif <= 1'b0;
                            kalan_negatif <= 1'b0;
                            durum         <= BOL_DUZELT;
                        end else begin
                            bolum         <= yeni_isaretli ? mutlak(bolunen_i)
                                                           : bolunen_i;
                            kalan         <= '0;
                            bolum_negatif <= yeni_isaretli
                                             && (bolunen_i[VERI_BIT-1]
                                                 ^ bolen_i[VERI_BIT-1]);
                            kalan_negatif <= yeni_isaretli
                                             && bolunen_i[VERI_BIT-1];
                            durum         <= BOL_HESAPLA;
                        end
                    end
                end

                BOL_HESAPLA: begin
                    gecerli_o <= 1'b0;
                    kalan     <= kalan_sonraki;
                    bolum     <= bolum_sonraki;
                    if (sayac == '0) begin
                        durum <= BOL_DUZELT;
                    end else begin
                        sayac <= sayac - SAYAC_BIT'(1);
                    end
                end

                BOL_DUZELT: begin
                    sonuc_o    <= secilen;
                    rd_adres_o <= rd_adres;
                    gecerli_o  <= 1'b1;
                    mesgul_o   <= 1'b0;
                    durum      <= BOL_BOSTA;
                end

                default: begin
                    durum     <= BOL_BOSTA;
                    mesgul_o  <= 1'b0;
                    gecerli_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
